// File: rtl/mux_dispatcher.sv
// rtl/mux_dispatcher.sv - steers one input stream into alpha/beta/gamma FIFOs, counting dropped words
//
// mux_dispatcher ports:
//   clk, nreset                          clock, synchronous active-low reset
//   in_valid, in_ready, in_data          producer stream
//   sel, cs                              target channel (0 alpha, 1 beta, 2 gamma, 3 none), chip select
//   alpha_valid/ready/data               alpha consumer stream (FIFO head)
//   beta_valid/ready/data                beta consumer stream (FIFO head)
//   gamma_valid/ready/data               gamma consumer stream (FIFO head)
//   drop_count                           saturating count of discarded words
//
// mux_dispatcher_fifo ports:
//   push/wdata in, pop in, valid/full/rdata out; rdata is the head word straight from storage.

module mux_dispatcher_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              valid,
  output logic              full,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  // A pop on an empty FIFO is ignored; a push into a full FIFO is allowed only
  // when the head leaves in the same cycle, so nothing is ever overwritten.
  assign do_pop  = pop & valid;
  assign do_push = push & (!full | do_pop);
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

module mux_dispatcher #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        sel,
  input  logic              cs,
  output logic              alpha_valid,
  input  logic              alpha_ready,
  output logic [DATA_W-1:0] alpha_data,
  output logic              beta_valid,
  input  logic              beta_ready,
  output logic [DATA_W-1:0] beta_data,
  output logic              gamma_valid,
  input  logic              gamma_ready,
  output logic [DATA_W-1:0] gamma_data,
  output logic [CNT_W-1:0]  drop_count
);

  logic             drop_sel;
  logic             target_ok;
  logic             accept;
  logic             alpha_full;
  logic             beta_full;
  logic             gamma_full;
  logic             push_alpha;
  logic             push_beta;
  logic             push_gamma;
  logic [CNT_W-1:0] drops;

  // Words with no destination take the drop path, which never stalls.
  assign drop_sel = !cs | (sel == 2'd3);

  // Only the addressed channel's state gates acceptance, so a stalled channel
  // never blocks traffic bound elsewhere.
  always_comb begin
    target_ok = 1'b1;
    case (sel)
      2'd0:    target_ok = !alpha_full | (alpha_valid & alpha_ready);
      2'd1:    target_ok = !beta_full  | (beta_valid  & beta_ready);
      2'd2:    target_ok = !gamma_full | (gamma_valid & gamma_ready);
      default: target_ok = 1'b1;
    endcase
  end

  assign in_ready   = drop_sel | target_ok;
  assign accept     = in_valid & in_ready;
  assign push_alpha = accept & !drop_sel & (sel == 2'd0);
  assign push_beta  = accept & !drop_sel & (sel == 2'd1);
  assign push_gamma = accept & !drop_sel & (sel == 2'd2);

  mux_dispatcher_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_alpha (
    .clk    (clk),
    .nreset (nreset),
    .push   (push_alpha),
    .wdata  (in_data),
    .pop    (alpha_ready),
    .valid  (alpha_valid),
    .full   (alpha_full),
    .rdata  (alpha_data)
  );

  mux_dispatcher_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_beta (
    .clk    (clk),
    .nreset (nreset),
    .push   (push_beta),
    .wdata  (in_data),
    .pop    (beta_ready),
    .valid  (beta_valid),
    .full   (beta_full),
    .rdata  (beta_data)
  );

  mux_dispatcher_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_gamma (
    .clk    (clk),
    .nreset (nreset),
    .push   (push_gamma),
    .wdata  (in_data),
    .pop    (gamma_ready),
    .valid  (gamma_valid),
    .full   (gamma_full),
    .rdata  (gamma_data)
  );

  // Saturating drop counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      drops <= '0;
    end else if (accept && drop_sel && (drops != {CNT_W{1'b1}})) begin
      drops <= drops + CNT_W'(1);
    end
  end

  assign drop_count = drops;

endmodule

// File: tb/tb_mux_dispatcher.sv
// tb/tb_mux_dispatcher.sv - randomized scoreboard bench for mux_dispatcher

module tb_mux_dispatcher;

  localparam int DW    = 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          in_valid = 1'b0;
  logic          cs = 1'b0;
  logic [1:0]    sel = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic          alpha_ready = 1'b0;
  logic          beta_ready = 1'b0;
  logic          gamma_ready = 1'b0;

  logic          in_ready, alpha_valid, beta_valid, gamma_valid;
  logic [DW-1:0] alpha_data, beta_data, gamma_data;
  logic [7:0]    drop_count;

  logic          s_in_ready, s_alpha_valid, s_beta_valid, s_gamma_valid;
  logic [DW-1:0] s_alpha_data, s_beta_data, s_gamma_data;
  logic [1:0]    s_drop_count;

  always #5 clk = ~clk;

  mux_dispatcher #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sel(sel), .cs(cs),
    .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha_data(alpha_data),
    .beta_valid(beta_valid), .beta_ready(beta_ready), .beta_data(beta_data),
    .gamma_valid(gamma_valid), .gamma_ready(gamma_ready), .gamma_data(gamma_data),
    .drop_count(drop_count)
  );

  // Narrow-counter instance sharing the same stimulus, for drop saturation at 3.
  mux_dispatcher #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(2)) dut_s (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .sel(sel), .cs(cs),
    .alpha_valid(s_alpha_valid), .alpha_ready(alpha_ready), .alpha_data(s_alpha_data),
    .beta_valid(s_beta_valid), .beta_ready(beta_ready), .beta_data(s_beta_data),
    .gamma_valid(s_gamma_valid), .gamma_ready(gamma_ready), .gamma_data(s_gamma_data),
    .drop_count(s_drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-channel queues of words accepted but not yet consumed,
  // and the total number of dropped words since the last reset.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int            model_drops = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [DW-1:0] qfront(input int ch);
    case (ch)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int ch);
    case (ch)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic qpush(input int ch, input logic [DW-1:0] d);
    case (ch)
      0:       q0.push_back(d);
      1:       q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic mon_chan(input int ch, input string nm, input logic v, input logic r,
                          input logic [DW-1:0] d, input logic v2, input logic [DW-1:0] d2);
    int sz;
    sz = qsize(ch);
    chk({nm, "_valid"}, {31'd0, v}, {31'd0, sz != 0});
    chk({nm, "_valid_c2"}, {31'd0, v2}, {31'd0, sz != 0});
    if (sz != 0) begin
      chk({nm, "_data"}, {24'd0, d}, {24'd0, qfront(ch)});
      chk({nm, "_data_c2"}, {24'd0, d2}, {24'd0, qfront(ch)});
      if (r) qpop(ch);
    end
  endtask

  // Monitor: samples mid-cycle the state left by the last rising edge and the
  // handshake about to happen at the next one.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_chan(0, "alpha", alpha_valid, alpha_ready, alpha_data, s_alpha_valid, s_alpha_data);
      mon_chan(1, "beta",  beta_valid,  beta_ready,  beta_data,  s_beta_valid,  s_beta_data);
      mon_chan(2, "gamma", gamma_valid, gamma_ready, gamma_data, s_gamma_valid, s_gamma_data);
      chk("drop_count", {24'd0, drop_count}, (model_drops > 255) ? 32'd255 : 32'(model_drops));
      chk("drop_count_c2", {30'd0, s_drop_count}, (model_drops > 3) ? 32'd3 : 32'(model_drops));
    end
  end

  // One producer cycle; acc reports whether the model says the word was taken.
  task automatic cycle(input logic v, input logic c, input logic [1:0] s, input logic [DW-1:0] d,
                       input logic ar, input logic br, input logic gr, output logic acc);
    logic exp_rdy;
    @(posedge clk); #1;
    in_valid = v; cs = c; sel = s; in_data = d;
    alpha_ready = ar; beta_ready = br; gamma_ready = gr;
    @(negedge clk); #1;
    // Queues already reflect the pop the monitor saw for the coming edge.
    exp_rdy = (!c || s == 2'd3) ? 1'b1 : (qsize(int'(s)) < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("in_ready_c2", {31'd0, s_in_ready}, {31'd0, exp_rdy});
    acc = v & exp_rdy;
    if (acc) begin
      if (!c || s == 2'd3) model_drops++;
      else qpush(int'(s), d);
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    nreset = 1'b0; in_valid = 1'b0;
    @(negedge clk); #1;
    q0.delete(); q1.delete(); q2.delete();
    model_drops = 0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    nreset = 1'b1;
  endtask

  task automatic idle(input int n, input logic ar, input logic br, input logic gr);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 2'd0, 8'h00, ar, br, gr, a);
  endtask

  initial begin
    logic acc;
    int   tries;

    do_reset();
    idle(1, 1'b0, 1'b0, 1'b0);

    // Single beta word, visible the cycle after acceptance.
    cycle(1'b1, 1'b1, 2'd1, 8'h5A, 1'b0, 1'b0, 1'b0, acc);
    idle(2, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0, 1'b1, 1'b0);

    // Gamma stalls at two words; third is held off, alpha still accepted.
    cycle(1'b1, 1'b1, 2'd2, 8'h11, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 2'd2, 8'h22, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 2'd2, 8'h33, 1'b0, 1'b0, 1'b0, acc);
    chk("gamma_third_stalled", {31'd0, acc}, 32'd0);
    cycle(1'b1, 1'b1, 2'd0, 8'h44, 1'b0, 1'b0, 1'b0, acc);
    chk("alpha_while_gamma_full", {31'd0, acc}, 32'd1);
    tries = 0;
    do begin
      cycle(1'b1, 1'b1, 2'd2, 8'h33, 1'b0, 1'b0, 1'b1, acc);
      tries++;
    end while (!acc && tries < 10);
    chk("gamma_pending_taken", {31'd0, acc}, 32'd1);
    idle(4, 1'b1, 1'b1, 1'b1);

    // Drop path: 3 with cs=0, 2 with sel=3, then one more to push past 3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 2'(i), 8'(i), 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 2'd3, 8'(i), 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b0, 2'd1, 8'hEE, 1'b0, 1'b0, 1'b0, acc);
    idle(1, 1'b0, 1'b0, 1'b0);

    // Full alpha with a pop in the same cycle as a push.
    cycle(1'b1, 1'b1, 2'd0, 8'h55, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 2'd0, 8'h66, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 2'd0, 8'h77, 1'b1, 1'b0, 1'b0, acc);
    chk("alpha_push_on_full_pop", {31'd0, acc}, 32'd1);
    idle(1, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0, 1'b0);

    // Reset discards beta contents.
    cycle(1'b1, 1'b1, 2'd1, 8'hA1, 1'b0, 1'b0, 1'b0, acc);
    cycle(1'b1, 1'b1, 2'd1, 8'hA2, 1'b0, 1'b0, 1'b0, acc);
    do_reset();
    idle(3, 1'b1, 1'b1, 1'b1);

    // Randomized traffic with random backpressure and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
      end else begin
        cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
              2'($urandom_range(0, 3)), 8'($urandom),
              1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 3),
              1'($urandom_range(0, 9) < 8), acc);
      end
    end

    idle(DEPTH + 2, 1'b1, 1'b1, 1'b1);
    chk("drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_dispatcher.md
Name: mux_dispatcher

Overview:
- Transmit-side counterpart of the alpha/beta/gamma select mux: takes a single 8-bit input stream and steers each word to one of three output channels (alpha, beta, gamma) using `sel`, gated by `cs`.
- Each output channel has a small FIFO and a valid/ready handshake, so a stalled consumer backpressures only its own channel.
- Words addressed to no channel are discarded and counted.
- Sits between a single producer and three independent consumers.

Parameters:
- DATA_W, 8: width of the data word on the input and on every output.
- DEPTH, 2: entries per output FIFO. Power of two, at least 2.
- CNT_W, 8: width of the drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- nreset  input  1  synchronous active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  dispatcher accepts the word this cycle.
- in_data  input  DATA_W  word to dispatch.
- sel  input  2  target channel: 0 = alpha, 1 = beta, 2 = gamma, 3 = none.
- cs  input  1  chip select; 0 means discard the word.
- alpha_valid  output  1  alpha FIFO is non-empty.
- alpha_ready  input  1  alpha consumer takes the head word.
- alpha_data  output  DATA_W  alpha head word.
- beta_valid / beta_ready / beta_data  output / input / output  1 / 1 / DATA_W  same as alpha, for beta.
- gamma_valid / gamma_ready / gamma_data  output / input / output  1 / 1 / DATA_W  same as alpha, for gamma.
- drop_count  output  CNT_W  number of discarded words, saturating.

Behaviour:
- Reset: clk and nreset are the only clock and reset. Reset is synchronous and active-low: nreset=0 at a rising edge of clk resets the block.
  - All FIFOs are emptied; pointers and counts go to 0.
  - alpha_valid, beta_valid and gamma_valid are 0 from the cycle after reset.
  - drop_count is 0.
  - *_data is don't-care while the matching *_valid is 0.
- Reset mid-operation: any words held in the FIFOs are discarded and never appear at the outputs.
- Accept condition: accept = in_valid & in_ready. in_data, sel and cs are sampled only when accept is 1.
- in_ready (combinational from sel, cs, FIFO state and the target channel's *_ready):
  - If cs=0 or sel=3: in_ready=1 (drop path, never stalls).
  - Otherwise in_ready = !full(target) | (target_valid & target_ready). This allows a push into a full FIFO in the same cycle as a pop.
- Routing on accept:
  - cs=1, sel=0/1/2: the word is pushed into the alpha/beta/gamma FIFO.
  - cs=0 or sel=3: the word is discarded; drop_count increments by 1 and saturates at 2^CNT_W-1.
- Outputs:
  - x_valid = FIFO x non-empty.
  - x_data = head of FIFO x, driven straight from storage with no combinational path from in_data.
  - Pop when x_valid & x_ready.
- Latency: a word accepted at edge N is visible on x_valid/x_data from edge N onward, i.e. in cycle N+1. There is no same-cycle bypass, including when the FIFO is empty.
- Simultaneous push and pop on the same FIFO:
  - Both take effect and the occupancy is unchanged.
  - On a full FIFO this is legal and loses nothing.
  - On an empty FIFO, the pop cannot happen (valid=0), so only the push takes effect.
- Ordering and stability:
  - Words are delivered in acceptance order within each channel. There is no ordering relation between channels.
  - x_data is held stable while x_valid=1 and x_ready=0.
- Independence: a full or stalled channel does not affect acceptance for other channels or for the drop path.
- Pointers wrap modulo DEPTH; occupancy is tracked with a counter of width clog2(DEPTH)+1.
- x_ready while x_valid=0 has no effect.

Test Plan:
- Reset, then in_valid=1, cs=1, sel=1, in_data=0x5A for one cycle -> in the next cycle beta_valid=1 and beta_data=0x5A; alpha_valid=0, gamma_valid=0; drop_count=0.
- Hold gamma_ready=0 and push 0x11, 0x22, then 0x33 to gamma (DEPTH=2) -> in_ready=0 on the third word and it stays pending. Raise gamma_ready -> the consumer sees 0x11, then 0x22, then 0x33.
- Gamma full and stalled; push 0x44 to alpha in the same cycle -> accepted; alpha_valid=1 next cycle; gamma is unchanged.
- Send 3 words with cs=0 and 2 words with cs=1, sel=3 -> in_ready=1 throughout; no output valid rises; drop_count=5. With CNT_W=2, send 6 drops -> drop_count saturates at 3.
- Alpha FIFO full, alpha_ready=1, push 0x77 to alpha in the same cycle -> the push is accepted, the occupancy stays 2, and 0x77 is delivered after the resident words.
- Fill beta with 2 words, assert nreset=0 for one edge -> the next cycle has beta_valid=0 and drop_count=0; the old words never appear on beta_data.
